// File: rtl/local_mem_pkg.sv
// Shared types and constants for the LOCAL_MEM request controller.
package local_mem_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int BE_W       = DEF_DATA_W / 8;
   localparam logic [BE_W-1:0] FULL_BE = {BE_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_CAPT,
      RSP,
      RMW_ADDR,
      RMW_MRG,
      RMW_WR
   } state_t;

endpackage

// File: rtl/local_mem_be_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes take the new word,
// the rest keep the word read back from LOCAL_MEM.
module local_mem_be_merge
   import local_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_N   = DATA_W / 8
) (
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_word,
   input  logic [BE_N-1:0]   be,
   output logic [DATA_W-1:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < BE_N; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/local_mem_ctrl.sv
// Request-side controller for the LOCAL_MEM single-port BRAM: one request in
// flight, byte-enabled writes become full writes or read-modify-write cycles.
module local_mem_ctrl
   import local_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_data,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_din,
   input  logic [DATA_W-1:0]   mem_dout
);

   localparam int BE_N = DATA_W / 8;

   state_t              state, next_state;
   logic [DATA_W-1:0]   wr_data, wr_data_d;
   logic [BE_N-1:0]     wr_be, wr_be_d;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_din_d;
   logic                rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_d;
   logic [DATA_W-1:0]   merged;

   assign req_ready = (state == IDLE) && !rst;

   local_mem_be_merge #(
      .DATA_W (DATA_W),
      .BE_N   (BE_N)
   ) u_merge (
      .old_word (mem_dout),
      .new_word (wr_data),
      .be       (wr_be),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_data   <= '0;
         wr_be     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= next_state;
         wr_data   <= wr_data_d;
         wr_be     <= wr_be_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_din   <= mem_din_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
      end
   end

   // RAM-side outputs are computed for the next state so that they are
   // registered yet line up with the state they belong to.
   always_comb begin
      next_state  = state;
      wr_data_d   = wr_data;
      wr_be_d     = wr_be;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_din_d   = mem_din;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!req_wr) begin
                  mem_addr_d = req_addr;
                  next_state = RD_ADDR;
               end else if (&req_be) begin
                  mem_addr_d = req_addr;
                  mem_din_d  = req_data;
                  mem_we_d   = 1'b1;
                  next_state = WR;
               end else if (|req_be) begin
                  mem_addr_d = req_addr;
                  wr_data_d  = req_data;
                  wr_be_d    = req_be;
                  next_state = RMW_ADDR;
               end
               // A write with no byte enables is accepted and dropped here.
            end
         end
         WR:       next_state = IDLE;
         RD_ADDR:  next_state = RD_CAPT;
         RD_CAPT: begin
            rsp_data_d  = mem_dout;
            rsp_valid_d = 1'b1;
            next_state  = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         RMW_ADDR: next_state = RMW_MRG;
         RMW_MRG: begin
            mem_din_d  = merged;
            mem_we_d   = 1'b1;
            next_state = RMW_WR;
         end
         RMW_WR:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_local_mem_ctrl.sv
// Directed and random self-checking bench for local_mem_ctrl with a
// 1-cycle-latency LOCAL_MEM model attached to the RAM port.
module tb_local_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [9:0]  req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic        clear_ram;
   logic [31:0] ram [1024];
   logic [31:0] mdl [1024];

   int errors = 0;
   int checks = 0;

   local_mem_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // LOCAL_MEM stand-in: registered read, write on wea.
   always @(posedge clk) begin
      if (clear_ram) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_din;
      end
      mem_dout <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents a request, waits for acceptance and returns in the cycle after
   // the accept edge with the request fields scrambled.
   task automatic applyStimulus(input logic wr, input logic [9:0] addr,
                                input logic [31:0] data, input logic [3:0] be);
      int n;
      req_wr    = wr;
      req_addr  = addr;
      req_data  = data;
      req_be    = be;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      checkOutput("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      req_wr    = ~wr;
      req_addr  = ~addr;
      req_data  = ~data;
      req_be    = ~be;
   endtask

   task automatic doWrite(input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int weCycle,
                          output int doneCycle);
      applyStimulus(1'b1, addr, data, be);
      weCycle   = 0;
      doneCycle = 0;
      for (int n = 1; n <= 8; n++) begin
         if (mem_we && weCycle == 0) weCycle = n;
         if (req_ready) begin
            doneCycle = n;
            break;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mdl[addr][8*i +: 8] = data[8*i +: 8];
      end
   endtask

   task automatic doRead(input logic [9:0] addr, input int hold,
                         output logic [31:0] data, output int lat);
      logic [31:0] held;
      rsp_ready = (hold == 0);
      applyStimulus(1'b0, addr, 32'h0, 4'h0);
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
      data = rsp_data;
      held = rsp_data;
      for (int k = 0; k < hold; k++) begin
         checkOutput("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
         checkOutput("bp_rsp_data", rsp_data, held);
         checkOutput("bp_req_ready", {31'h0, req_ready}, 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      checkOutput("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
      checkOutput("req_ready_after_rsp", {31'h0, req_ready}, 32'h1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      int          lat, weC, doneC, expWe, hold;

      rst       = 1'b1;
      clear_ram = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_be    = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
      repeat (3) tick();

      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h0);
      checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
      checkOutput("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
      checkOutput("rst_mem_din", mem_din, 32'h0);
      checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("rst_rsp_data", rsp_data, 32'h0);
      rst       = 1'b0;
      clear_ram = 1'b0;
      tick();
      checkOutput("idle_req_ready", {31'h0, req_ready}, 32'h1);

      $display("[TB] full writes then reads");
      for (int i = 0; i < 8; i++) begin
         doWrite(10'(i), 32'hA5A50000 + i, 4'hF, weC, doneC);
         checkOutput("full_wr_we_cycle", weC, 32'd1);
         checkOutput("full_wr_done_cycle", doneC, 32'd2);
      end
      for (int i = 0; i < 8; i++) begin
         doRead(10'(i), 0, rd, lat);
         checkOutput("full_rd_data", rd, 32'hA5A50000 + i);
         checkOutput("full_rd_latency", lat, 32'd3);
      end

      $display("[TB] partial write");
      doWrite(10'h010, 32'h11223344, 4'hF, weC, doneC);
      doWrite(10'h010, 32'hAABBCCDD, 4'b0101, weC, doneC);
      checkOutput("rmw_we_cycle", weC, 32'd3);
      checkOutput("rmw_done_cycle", doneC, 32'd4);
      doRead(10'h010, 0, rd, lat);
      checkOutput("rmw_rd_data", rd, 32'h11BB33DD);

      $display("[TB] backpressure at last address");
      doWrite(10'h3FF, 32'hDEADBEEF, 4'hF, weC, doneC);
      doRead(10'h3FF, 5, rd, lat);
      checkOutput("bp_rd_data", rd, 32'hDEADBEEF);
      checkOutput("bp_rd_latency", lat, 32'd3);

      $display("[TB] zero byte enables");
      doWrite(10'h005, 32'h12345678, 4'hF, weC, doneC);
      doWrite(10'h005, 32'h99999999, 4'h0, weC, doneC);
      checkOutput("zero_be_we_cycle", weC, 32'd0);
      checkOutput("zero_be_done_cycle", doneC, 32'd1);
      doRead(10'h005, 0, rd, lat);
      checkOutput("zero_be_rd_data", rd, 32'h12345678);

      $display("[TB] reset during read-modify-write");
      doWrite(10'h020, 32'hCAFEF00D, 4'hF, weC, doneC);
      applyStimulus(1'b1, 10'h020, 32'h11111111, 4'b0011);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("rst_rmw_mem_we", {31'h0, mem_we}, 32'h0);
      checkOutput("rst_rmw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      rst = 1'b0;
      weC = 0;
      for (int n = 0; n < 4; n++) begin
         if (mem_we) weC++;
         tick();
      end
      checkOutput("rst_rmw_no_write", weC, 32'd0);
      checkOutput("rst_rmw_ready", {31'h0, req_ready}, 32'h1);
      doRead(10'h020, 0, rd, lat);
      checkOutput("rst_rmw_old_data", rd, 32'hCAFEF00D);

      $display("[TB] reset during pending response");
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 10'h3FF, 32'h0, 4'h0);
      tick();
      tick();
      checkOutput("pend_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      rst = 1'b1;
      tick();
      checkOutput("rst_rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
      checkOutput("rst_rsp_data_clear", rsp_data, 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("rst_rsp_ready_back", {31'h0, req_ready}, 32'h1);

      $display("[TB] random soak");
      for (int t = 0; t < 1000; t++) begin
         a = ($urandom_range(0, 1) == 1) ? 10'h3E0 : 10'h000;
         a = a | 10'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            expWe = (b == 4'hF) ? 1 : ((b == 4'h0) ? 0 : 3);
            doWrite(a, d, b, weC, doneC);
            checkOutput("soak_we_cycle", weC, 32'(expWe));
         end else begin
            hold = $urandom_range(0, 2);
            doRead(a, hold, rd, lat);
            checkOutput("soak_rd_data", rd, mdl[a]);
            checkOutput("soak_rd_latency", lat, 32'd3);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
